// File: rtl/domain_demux_fifo.sv
// Steers a shared, domain-tagged byte stream into two fully separate FIFOs (D1, D2).
// Each domain keeps its own storage, pointers and count so that neither domain's state reaches the other's outputs.
module domain_demux_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush0,
  input  logic              flush1,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic [PTR_W:0]    out0_count,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic [PTR_W:0]    out1_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [PTR_W-1:0]  wr_ptr0, rd_ptr0;
  logic [PTR_W:0]    cnt0;
  logic              full0, push0, pop0;

  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [PTR_W-1:0]  wr_ptr1, rd_ptr1;
  logic [PTR_W:0]    cnt1;
  logic              full1, push1, pop1;

  assign full0 = (cnt0 == FULL_CNT);
  assign full1 = (cnt1 == FULL_CNT);

  // in_sel is public, so it is the only term allowed to combine the two domains.
  assign in_ready = in_sel ? !full1 : !full0;

  // Push terms use only their own domain's full flag; flush wins over any access.
  assign push0 = in_valid && !in_sel && !full0 && !flush0;
  assign push1 = in_valid &&  in_sel && !full1 && !flush1;
  assign pop0  = out0_valid && out0_ready && !flush0;
  assign pop1  = out1_valid && out1_ready && !flush1;

  assign out0_valid = (cnt0 != '0);
  assign out1_valid = (cnt1 != '0);
  assign out0_count = cnt0;
  assign out1_count = cnt1;

  // An empty FIFO presents zero rather than the last popped entry.
  assign out0_data = out0_valid ? mem0[rd_ptr0] : '0;
  assign out1_data = out1_valid ? mem1[rd_ptr1] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n || flush0) begin
      wr_ptr0 <= '0;
      rd_ptr0 <= '0;
      cnt0    <= '0;
      for (int i = 0; i < DEPTH; i++) mem0[i] <= '0;
    end else begin
      if (push0) begin
        mem0[wr_ptr0] <= in_data;
        wr_ptr0       <= wr_ptr0 + 1'b1;
      end
      if (pop0) rd_ptr0 <= rd_ptr0 + 1'b1;
      case ({push0, pop0})
        2'b10:   cnt0 <= cnt0 + 1'b1;
        2'b01:   cnt0 <= cnt0 - 1'b1;
        default: cnt0 <= cnt0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush1) begin
      wr_ptr1 <= '0;
      rd_ptr1 <= '0;
      cnt1    <= '0;
      for (int i = 0; i < DEPTH; i++) mem1[i] <= '0;
    end else begin
      if (push1) begin
        mem1[wr_ptr1] <= in_data;
        wr_ptr1       <= wr_ptr1 + 1'b1;
      end
      if (pop1) rd_ptr1 <= rd_ptr1 + 1'b1;
      case ({push1, pop1})
        2'b10:   cnt1 <= cnt1 + 1'b1;
        2'b01:   cnt1 <= cnt1 - 1'b1;
        default: cnt1 <= cnt1;
      endcase
    end
  end

endmodule

// File: tb/tb_domain_demux_fifo.sv
// Bench for domain_demux_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_domain_demux_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0, in_sel = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              flush0 = 1'b0, flush1 = 1'b0;
  logic              out0_valid, out0_ready = 1'b0;
  logic [DATA_W-1:0] out0_data;
  logic [PTR_W:0]    out0_count;
  logic              out1_valid, out1_ready = 1'b0;
  logic [DATA_W-1:0] out1_data;
  logic [PTR_W:0]    out1_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];

  domain_demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
    .flush0(flush0), .flush1(flush1),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data), .out0_count(out0_count),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data), .out1_count(out1_count)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two byte queues updated from the rules at each rising edge.
  always @(posedge clk) begin
    bit w;
    logic [DATA_W-1:0] drop;
    started = 1'b1;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      w = in_valid && (in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
      if (flush0) q0.delete();
      else begin
        if (out0_ready && q0.size() > 0) drop = q0.pop_front();
        if (w && !in_sel) q0.push_back(in_data);
      end
      if (flush1) q1.delete();
      else begin
        if (out1_ready && q1.size() > 0) drop = q1.pop_front();
        if (w && in_sel) q1.push_back(in_data);
      end
    end
  end

  // Compare process: mid-low-phase, after the driver has settled the inputs.
  always @(negedge clk) begin
    #5;
    if (started) begin
      check("in_ready",   32'(in_ready),   32'(in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH)));
      check("out0_valid", 32'(out0_valid), 32'(q0.size() > 0));
      check("out0_count", 32'(out0_count), 32'(q0.size()));
      check("out0_data",  32'(out0_data),  (q0.size() > 0) ? 32'(q0[0]) : 32'd0);
      check("out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
      check("out1_count", 32'(out1_count), 32'(q1.size()));
      check("out1_data",  32'(out1_data),  (q1.size() > 0) ? 32'(q1[0]) : 32'd0);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic sel, input logic [DATA_W-1:0] d);
    in_valid = 1'b1; in_sel = sel; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop0(input logic [DATA_W-1:0] exp);
    check("pop0_head", 32'(out0_data), 32'(exp));
    out0_ready = 1'b1;
    tick();
    out0_ready = 1'b0;
  endtask

  initial begin
    tick(); tick();
    check("rst_count0", 32'(out0_count), 32'd0);
    check("rst_valid1", 32'(out1_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // In-order delivery on D1; D2 stays silent.
    push(1'b0, 8'hA1); push(1'b0, 8'hA2); push(1'b0, 8'hA3);
    check("t1_count", 32'(out0_count), 32'd3);
    check("t1_head",  32'(out0_data),  32'hA1);
    out0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_drain_count", 32'(out0_count), 32'(2 - i));
      check("t1_drain_data",  32'(out0_data),  (i == 0) ? 32'hA2 : (i == 1) ? 32'hA3 : 32'h0);
      check("t1_out1_valid",  32'(out1_valid), 32'd0);
      check("t1_out1_data",   32'(out1_data),  32'd0);
    end
    out0_ready = 1'b0;

    // Fill D2; in_ready follows the selected domain.
    for (int i = 0; i < 4; i++) push(1'b1, 8'hB0 + 8'(i));
    in_sel = 1'b1; #1;
    check("t2_count1",  32'(out1_count), 32'd4);
    check("t2_rdy_d2",  32'(in_ready),   32'd0);
    in_sel = 1'b0; #1;
    check("t2_rdy_d1",  32'(in_ready),   32'd1);
    push(1'b0, 8'hC1);
    check("t2_count0",  32'(out0_count), 32'd1);
    check("t2_head0",   32'(out0_data),  32'hC1);

    // Full D2 with concurrent pop and write: pop only.
    in_valid = 1'b1; in_sel = 1'b1; in_data = 8'hEE; out1_ready = 1'b1;
    tick();
    in_valid = 1'b0; out1_ready = 1'b0;
    check("t3_count1", 32'(out1_count), 32'd3);
    check("t3_head1",  32'(out1_data),  32'hB1);
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (4) tick();
    out0_ready = 1'b0; out1_ready = 1'b0;

    // Wrap-around on D1.
    for (int i = 0; i < 4; i++) push(1'b0, 8'h10 + 8'(i));
    pop0(8'h10); pop0(8'h11);
    push(1'b0, 8'h14); push(1'b0, 8'h15);
    check("t4_count", 32'(out0_count), 32'd4);
    pop0(8'h12); pop0(8'h13); pop0(8'h14); pop0(8'h15);
    check("t4_empty", 32'(out0_count), 32'd0);

    // Flush D1 beats a same-cycle write; D2 untouched.
    push(1'b0, 8'h21); push(1'b0, 8'h22); push(1'b1, 8'h77);
    flush0 = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h55;
    tick();
    flush0 = 1'b0; in_valid = 1'b0;
    check("t5_count0", 32'(out0_count), 32'd0);
    check("t5_valid0", 32'(out0_valid), 32'd0);
    check("t5_data0",  32'(out0_data),  32'd0);
    check("t5_count1", 32'(out1_count), 32'd1);
    check("t5_data1",  32'(out1_data),  32'h77);
    push(1'b0, 8'h66);
    check("t5_no55",   32'(out0_data),  32'h66);

    // Reset mid-traffic discards everything.
    push(1'b0, 8'h31); push(1'b1, 8'h41);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_count0", 32'(out0_count), 32'd0);
    check("t6_count1", 32'(out1_count), 32'd0);
    check("t6_valid0", 32'(out0_valid), 32'd0);
    check("t6_valid1", 32'(out1_valid), 32'd0);
    check("t6_data0",  32'(out0_data),  32'd0);
    check("t6_data1",  32'(out1_data),  32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid   = ($urandom_range(0, 99) < 60);
      in_sel     = 1'($urandom);
      in_data    = 8'($urandom);
      out0_ready = ($urandom_range(0, 99) < 45);
      out1_ready = ($urandom_range(0, 99) < 45);
      flush0     = ($urandom_range(0, 31) == 0);
      flush1     = ($urandom_range(0, 31) == 0);
      rst_n      = ($urandom_range(0, 199) != 0);
      tick();
    end
    in_valid = 1'b0; flush0 = 1'b0; flush1 = 1'b0; rst_n = 1'b1;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
